// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
  localparam int   ITER    = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [33:0] shifted;
  logic [33:0] trial;

  // One extra bit of headroom so the borrow lands in trial[33].
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {2'b00, divisor_i};
  assign q_o     = ~trial[33];
  assign rem_o   = trial[33] ? shifted[32:0] : trial[32:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) with HI/LO result registers.
// state | meaning: IDLE wait for start, RUN iterating (32 cycles), DONE one-cycle done pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        op_q, qm1_q, qneg_q, rneg_q;
  logic        busy_q, done_q, dz_q;
  logic [31:0] opnd_q, mq_q, hi_q, lo_q;
  logic [32:0] acc_q;

  logic [32:0] opnd_ext, booth_sum, booth_acc_d, div_rem_d, acc_d;
  logic [31:0] booth_mq_d, div_mq_d, mq_d, quo, rem, res_hi, res_lo;
  logic        div_q_bit;

  assign opnd_ext = {opnd_q[31], opnd_q};

  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + opnd_ext;
      2'b10:   booth_sum = acc_q - opnd_ext;
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_acc_d = {booth_sum[32], booth_sum[32:1]};
  assign booth_mq_d  = {booth_sum[0], mq_q[31:1]};

  div_step u_div_step (
    .rem_i    (acc_q),
    .bit_i    (mq_q[31]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem_d),
    .q_o      (div_q_bit)
  );

  assign div_mq_d = {mq_q[30:0], div_q_bit};
  assign acc_d    = (op_q == OP_DIV) ? div_rem_d : booth_acc_d;
  assign mq_d     = (op_q == OP_DIV) ? div_mq_d : booth_mq_d;

  // Magnitude quotient/remainder get their signs back only on the final iteration.
  assign quo    = div_mq_d;
  assign rem    = div_rem_d[31:0];
  assign res_hi = (op_q == OP_DIV) ? (rneg_q ? (~rem + 32'd1) : rem) : booth_acc_d[31:0];
  assign res_lo = (op_q == OP_DIV) ? (qneg_q ? (~quo + 32'd1) : quo) : booth_mq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            cnt_q  <= '0;
            dz_q   <= 1'b0;
            qm1_q  <= 1'b0;
            acc_q  <= '0;
            qneg_q <= a[31] ^ b[31];
            rneg_q <= a[31];
            busy_q <= 1'b1;
            if (op == OP_DIV) begin
              opnd_q <= abs32(b);
              mq_q   <= abs32(a);
              if (b == '0) begin
                dz_q    <= 1'b1;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= RUN;
              end
            end else begin
              opnd_q  <= a;
              mq_q    <= b;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          qm1_q <= mq_q[0];
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, bcnt, dcnt;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at edge E, observe 40 edges; optionally pulse a stray start at edge E+11.
  task automatic run_op(input logic o, input logic [31:0] va, input logic [31:0] vb,
                        input bit stray, output int latency, output int busy_cycles,
                        output int dones);
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    latency = -1; busy_cycles = 0; dones = 0;
    if (busy) busy_cycles++;
    if (done) begin dones++; latency = 0; end
    for (int i = 1; i <= 40; i++) begin
      if (stray && i == 11) begin
        op = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        if (latency < 0) latency = i;
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1'b1;

    run_op(1'b0, 32'd7, 32'd6, 1'b0, lat, bcnt, dcnt);
    chk("mul7x6_hi", hi, 32'h0000_0000);
    chk("mul7x6_lo", lo, 32'h0000_002A);
    chk("mul7x6_lat", lat, 32'd32);
    chk("mul7x6_busy", bcnt, 32'd33);
    chk("mul7x6_dones", dcnt, 32'd1);

    run_op(1'b0, -32'sd3, 32'd5, 1'b0, lat, bcnt, dcnt);
    chk("mulm3x5_hi", hi, 32'hFFFF_FFFF);
    chk("mulm3x5_lo", lo, 32'hFFFF_FFF1);

    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bcnt, dcnt);
    chk("mulmin_hi", hi, 32'h4000_0000);
    chk("mulmin_lo", lo, 32'h0000_0000);

    run_op(1'b1, -32'sd7, 32'd2, 1'b0, lat, bcnt, dcnt);
    chk("divm7_2_lo", lo, 32'hFFFF_FFFD);
    chk("divm7_2_hi", hi, 32'hFFFF_FFFF);
    chk("divm7_2_dz", {31'd0, div_zero}, 32'd0);
    chk("divm7_2_lat", lat, 32'd32);

    run_op(1'b1, 32'd100, -32'sd7, 1'b0, lat, bcnt, dcnt);
    chk("div100_m7_lo", lo, 32'hFFFF_FFF2);
    chk("div100_m7_hi", hi, 32'h0000_0002);
    chk("div100_m7_dz", {31'd0, div_zero}, 32'd0);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dcnt);
    chk("divwrap_lo", lo, 32'h8000_0000);
    chk("divwrap_hi", hi, 32'h0000_0000);
    chk("divwrap_dz", {31'd0, div_zero}, 32'd0);

    run_op(1'b0, 32'd7, 32'd6, 1'b0, lat, bcnt, dcnt);
    run_op(1'b1, 32'd5, 32'd0, 1'b0, lat, bcnt, dcnt);
    chk("div0_lat", lat, 32'd0);
    chk("div0_busy", bcnt, 32'd1);
    chk("div0_dones", dcnt, 32'd1);
    chk("div0_dz", {31'd0, div_zero}, 32'd1);
    chk("div0_hi", hi, 32'd0);
    chk("div0_lo", lo, 32'd42);

    @(negedge clk);
    op = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_clear", {31'd0, div_zero}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("after_div0_lo", lo, 32'd6);

    run_op(1'b0, 32'd7, 32'd6, 1'b1, lat, bcnt, dcnt);
    chk("stray_lo", lo, 32'd42);
    chk("stray_hi", hi, 32'd0);
    chk("stray_dones", dcnt, 32'd1);
    chk("stray_lat", lat, 32'd32);

    @(negedge clk);
    op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(1'b0, 32'd2, 32'd3, 1'b0, lat, bcnt, dcnt);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lat", lat, 32'd32);
    chk("post_rst_busy", bcnt, 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
